i2c_apb_arbiter: RTL

Round-robin arbiter sharing one COREI2C APB slave port, and therefore one physical I2C bus, between `N_REQ` sensor controllers such as the TMP117 poller. A requester owns the bus for a whole I2C transaction, from START to STOP. While it owns the bus, its APB signals pass straight to the core, and the core's INT is routed back only to it. An optional watchdog recovers the bus from a hung owner by issuing a forced STOP.

---
 rtl/i2c_apb_arbiter.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/i2c_apb_arbiter.sv
// i2c_apb_arbiter: round-robin owner-per-transaction arbiter sharing one COREI2C APB port
// Ports: i_req/i_done/o_gnt handshake per requester; per-requester APB slices
// (i_paddr 9b, i_psel/i_penable/i_pwrite, i_pwdata 8b) muxed to o_P* for the owner;
// i_PRDATA broadcast on o_prdata; i_INT routed to the owner on o_int; o_timeout
// pulses to an aborted owner.
// Build option I2C_ARB_WATCHDOG_EN: idle-owner watchdog that forces a STOP write.
module i2c_apb_arbiter #(
  parameter int          N_REQ          = 2,
  parameter logic [19:0] TIMEOUT_CYCLES = 20'd500000
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [N_REQ-1:0]     i_req,
  input  logic [N_REQ-1:0]     i_done,
  output logic [N_REQ-1:0]     o_gnt,
  input  logic [9*N_REQ-1:0]   i_paddr,
  input  logic [N_REQ-1:0]     i_psel,
  input  logic [N_REQ-1:0]     i_penable,
  input  logic [N_REQ-1:0]     i_pwrite,
  input  logic [8*N_REQ-1:0]   i_pwdata,
  output logic [7:0]           o_prdata,
  output logic [N_REQ-1:0]     o_int,
  output logic [N_REQ-1:0]     o_timeout,
  output logic [8:0]           o_PADDR,
  output logic                 o_PSEL,
  output logic                 o_PENABLE,
  output logic                 o_PWRITE,
  output logic [7:0]           o_PWDATA,
  input  logic [7:0]           i_PRDATA,
  input  logic                 i_INT
);
  localparam int LW = $clog2(N_REQ);
  typedef enum logic [1:0] {IDLE, GRANT, RELEASE, ABORT} state_t;
  state_t state_q, state_d;
  logic [LW-1:0] last_q, last_d, pick;
  logic [N_REQ-1:0] gnt_q, gnt_d, own_oh;
  logic found, grant, own_req, own_done, own_acc, ab, ab_b;
  // In GRANT/ABORT the owner is always last_q, so it doubles as the owner index.
  assign own_oh   = {{(N_REQ-1){1'b0}}, 1'b1} << last_q;
  assign own_req  = i_req[last_q];
  assign own_done = i_done[last_q];
  assign own_acc  = i_psel[last_q] & i_penable[last_q];
  assign grant    = state_q == GRANT;
  // Search upward starting just after the previous winner.
  always_comb begin
    found = 1'b0;
    pick  = last_q;
    for (int i = 1; i <= N_REQ; i++) begin
      if (!found && i_req[(int'(last_q) + i) % N_REQ]) begin
        found = 1'b1;
        pick  = LW'((int'(last_q) + i) % N_REQ);
      end
    end
  end
`ifdef I2C_ARB_WATCHDOG_EN
  logic [19:0] cnt_q, cnt_d;
  logic ph_q, ph_d;
  assign ab   = state_q == ABORT;
  assign ab_b = ab & ph_q;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    ph_d    = 1'b0;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
        last_d  = pick;
        cnt_d   = '0;
      end
      GRANT: begin
        cnt_d = own_acc ? '0 : cnt_q + 20'd1;
        // A release request beats a simultaneous expiry.
        if (own_done || !own_req) begin
          state_d = RELEASE;
          gnt_d   = '0;
        end else if (!own_acc && cnt_q == TIMEOUT_CYCLES - 20'd1) begin
          state_d = ABORT;
          gnt_d   = '0;
        end
      end
      RELEASE: state_d = IDLE;
      ABORT: begin
        ph_d    = !ph_q;
        state_d = ph_q ? RELEASE : ABORT;
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q <= '0;
      ph_q  <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      ph_q  <= ph_d;
    end
  end
`else
  logic unused_to;
  assign unused_to = ^TIMEOUT_CYCLES;
  assign ab        = 1'b0;
  assign ab_b      = 1'b0;
  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    case (state_q)
      IDLE: if (found) begin
        state_d = GRANT;
        gnt_d   = {{(N_REQ-1){1'b0}}, 1'b1} << pick;
        last_d  = pick;
      end
      GRANT: if (own_done || !own_req) begin
        state_d = RELEASE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end
`endif
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      last_q  <= LW'(N_REQ - 1);
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
    end
  end
  // Abort phases write 0xD0 (STOP) to control register 0.
  assign o_gnt     = gnt_q;
  assign o_int     = {N_REQ{i_INT}} & gnt_q;
  assign o_prdata  = i_PRDATA;
  assign o_timeout = ab_b ? own_oh : '0;
  assign o_PSEL    = grant ? i_psel[last_q] : ab;
  assign o_PENABLE = grant ? i_penable[last_q] : ab_b;
  assign o_PWRITE  = grant ? i_pwrite[last_q] : ab;
  assign o_PADDR   = grant ? i_paddr[9*last_q +: 9] : 9'd0;
  assign o_PWDATA  = grant ? i_pwdata[8*last_q +: 8] : (ab ? 8'hD0 : 8'd0);
endmodule
